// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among 4 requesters.
// Latency: grant is combinational with req; read data valid 1 cycle after grant.
// Backpressure: requesters hold req until gnt; optional zero-fill sweep (RAM_ARB_INIT_EN) blocks grants until done.
module ram_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              req,
    input  logic [3:0]              we,
    input  logic [4*ADDR_WIDTH-1:0] addr,
    input  logic [4*DATA_WIDTH-1:0] din,
    output logic [3:0]              gnt,
    output logic [3:0]              rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    init_done,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    input  logic [DATA_WIDTH-1:0]   ram_dout
);

    logic [1:0]            ptr;
    logic [1:0]            gnt_idx;
    logic                  any_gnt;
    logic                  run;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] addr_arr [4];
    logic [DATA_WIDTH-1:0] din_arr  [4];

`ifdef RAM_ARB_INIT_EN
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  sweep;

    // State register: reset always restarts the zero-fill sweep
    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    // Next state: leave INIT after the last address has been written
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == {ADDR_WIDTH{1'b1}})
            state_nxt = ST_RUN;
    end

    // Sweep address counter, advances once per INIT cycle
    always_ff @(posedge clk) begin
        if (reset)                 init_cnt <= '0;
        else if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end

    assign sweep     = (state == ST_INIT) && !reset;
    assign run       = (state == ST_RUN) && !reset;
    assign init_done = run;
`else
    assign run       = !reset;
    assign init_done = 1'b1;
`endif

    // Unpack the flat requester buses for readable indexing
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_arr[i] = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            din_arr[i]  = din[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search starting at ptr; first active request wins
    always_comb begin
        logic [1:0] idx;
        any_gnt = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (run && !any_gnt && req[idx]) begin
                any_gnt = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // RAM port mux: sweep, granted requester, or idle holding the last address
    always_comb begin
        gnt      = '0;
        ram_we   = 1'b0;
        ram_addr = last_addr;
        ram_din  = '0;
`ifdef RAM_ARB_INIT_EN
        if (sweep) begin
            ram_we   = 1'b1;
            ram_addr = init_cnt;
        end else
`endif
        if (any_gnt) begin
            gnt[gnt_idx] = 1'b1;
            ram_we       = we[gnt_idx];
            ram_addr     = addr_arr[gnt_idx];
            ram_din      = din_arr[gnt_idx];
        end
    end

    // Pointer rotation, read-valid pipeline and idle address hold
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            rvalid    <= '0;
            last_addr <= '0;
        end else begin
            rvalid <= gnt & ~we;
            if (any_gnt) begin
                ptr       <= gnt_idx + 2'd1;
                last_addr <= addr_arr[gnt_idx];
            end
        end
    end

    assign rdata = ram_dout;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a behavioural write-first RAM.
// Latency: checks sampled 3 time units after each rising edge.
// Backpressure: requests are held across cycles as the handshake allows.
module tb_ram_rr_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req;
    logic [3:0]      we;
    logic [4*AW-1:0] addr;
    logic [4*DW-1:0] din;
    logic [3:0]      gnt;
    logic [3:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            init_done;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;

    logic [DW-1:0]   mem [2**AW];

    int n_cmp = 0;
    int n_bad = 0;

    ram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .din(din),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .init_done(init_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // External RAM: registered read, write-first
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            ram_dout      <= ram_din;
        end else begin
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nx;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = 8'hFF;
        reset = 1'b1; req = '0; we = '0; addr = '0; din = '0;
        nx; nx;
        #2;
        // Reset state
        chk("rst_gnt", gnt, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rvalid", rvalid, 0);
`ifdef RAM_ARB_INIT_EN
        chk("rst_init_done", init_done, 0);
`else
        chk("rst_init_done", init_done, 1);
`endif
        nx;
        reset = 1'b0;

`ifdef RAM_ARB_INIT_EN
        // Zero-fill sweep ignores requests
        req = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            #2;
            chk("init_gnt", gnt, 0);
            chk("init_we", ram_we, 1);
            chk("init_addr", ram_addr, c);
            chk("init_din", ram_din, 0);
            chk("init_done_lo", init_done, 0);
            nx;
        end
`else
        // No sweep: usable immediately, idle port quiet
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("idle_done", init_done, 1);
            chk("idle_we", ram_we, 0);
            chk("idle_gnt", gnt, 0);
            nx;
        end
        req = 4'b1111;
`endif
        // Rotation with all requesters held, starting from ptr 0
        begin
            logic [3:0] seq [5];
            seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
            seq[3] = 4'b1000; seq[4] = 4'b0001;
            for (int c = 0; c < 5; c++) begin
                #2;
                chk("rr_done", init_done, 1);
                chk("rr_gnt", gnt, seq[c]);
                chk("rr_onehot", $countones(gnt), 1);
                nx;
            end
        end

`ifdef RAM_ARB_INIT_EN
        // Read back the whole RAM through requester 0
        for (int k = 0; k <= 16; k++) begin
            req = (k < 16) ? 4'b0001 : 4'b0000;
            addr[3:0] = AW'(k);
            #2;
            if (k > 0) begin
                chk("rb_rvalid", rvalid, 4'b0001);
                chk("rb_rdata", rdata, 0);
            end
            nx;
        end
`else
        req = 4'b0000;
        nx;
`endif

        // Requester 2 writes A5 to addr 3, requester 0 reads it back
        req = 4'b0100; we = 4'b0100;
        addr = {4'd0, 4'd3, 4'd0, 4'd0};
        din  = {8'h00, 8'hA5, 8'h00, 8'h00};
        #2;
        chk("wr_gnt", gnt, 4'b0100);
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, 3);
        chk("wr_din", ram_din, 8'hA5);
        nx;
        req = 4'b0001; we = 4'b0000;
        addr = {4'd0, 4'd0, 4'd0, 4'd3};
        din  = '0;
        #2;
        chk("rd_gnt", gnt, 4'b0001);
        chk("rd_we", ram_we, 0);
        chk("wr_no_rvalid", rvalid, 0);
        nx;
        req = 4'b0000;
        #2;
        chk("rd_rvalid", rvalid, 4'b0001);
        chk("rd_rdata", rdata, 8'hA5);
        chk("idle_gnt0", gnt, 0);
        chk("idle_we0", ram_we, 0);
        chk("idle_addr_hold", ram_addr, 3);
        nx;

        // Lone requester 3 granted repeatedly, then wrap to 0
        req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("solo3_gnt", gnt, 4'b1000);
            nx;
        end
        req = 4'b1001;
        #2; chk("wrap_gnt0", gnt, 4'b0001); nx;
        #2; chk("wrap_gnt3", gnt, 4'b1000); nx;

        // Two middle requesters alternate
        req = 4'b0110;
        #2; chk("mid_gnt1", gnt, 4'b0010); nx;
        #2; chk("mid_gnt2", gnt, 4'b0100); nx;
        #2; chk("mid_gnt1b", gnt, 4'b0010); nx;

        // Reset while a read is in flight
        req = 4'b0001; we = 4'b0000;
        #2; chk("pre_rst_gnt", gnt, 4'b0001); nx;
        reset = 1'b1; req = 4'b0000;
        #2;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_rvalid_old", rvalid, 4'b0001);
        nx;
        reset = 1'b0; req = 4'b1111;
        #2;
        chk("post_rst_rvalid", rvalid, 0);
`ifdef RAM_ARB_INIT_EN
        chk("post_rst_done", init_done, 0);
        chk("post_rst_addr", ram_addr, 0);
        chk("post_rst_we", ram_we, 1);
        chk("post_rst_gnt", gnt, 0);
        nx;
        #2; chk("post_rst_addr1", ram_addr, 1); nx;
        for (int c = 2; c < 16; c++) nx;
        #2;
        chk("post_rst_done1", init_done, 1);
`endif
        chk("post_rst_ptr0", gnt, 4'b0001);
        nx;
        req = 4'b0000;
        #2; chk("end_gnt", gnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
